// File: rtl/seq_pattern_tx_pkg.sv
`default_nettype none
// ============================================================================
// seq_pattern_tx_pkg : FSM encoding and shared active-low 7-segment digit table
// Revision: 1.0
// ============================================================================
package seq_pattern_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [6:0] c_seg_blank = 7'b1111111;

    // Entry n is the active-low segment pattern {a,b,c,d,e,f,g} for digit n.
    localparam logic [9:0][6:0] c_seg_digits = {
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

endpackage
`default_nettype wire

// File: rtl/seg7_digit.sv
`default_nettype none
// ============================================================================
// seg7_digit : combinational 4-bit value to active-low 7-segment decode
// Revision: 1.0
// ============================================================================
module seg7_digit
    import seq_pattern_tx_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = c_seg_blank;
        if (digit_i <= 4'd9) begin
            seg_o = c_seg_digits[digit_i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// seq_pattern_tx : serial MSB-first pattern transmitter with repeat, abort
//                  and a 7-segment display of the bit index on the line
// Revision: 1.0
// ============================================================================
module seq_pattern_tx
    import seq_pattern_tx_pkg::*;
#(
    parameter int unsigned                PATTERN_LEN = 10,
    parameter logic [PATTERN_LEN-1:0]     PATTERN     = 10'b1011001010,
    parameter int unsigned                BIT_PERIOD  = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   repeat_en,
    input  logic                   pattern_load,
    input  logic [PATTERN_LEN-1:0] pattern_in,
    output logic                   sequence_out,
    output logic                   busy,
    output logic                   done,
    output logic [6:0]             LED_out
);

    localparam int unsigned c_idx_w = $clog2(PATTERN_LEN);
    localparam int unsigned c_cnt_w = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

    localparam logic [c_idx_w-1:0] c_last_idx    = c_idx_w'(PATTERN_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_period_last = c_cnt_w'(BIT_PERIOD - 1);

    state_e                   state_q,   state_d;
    logic [PATTERN_LEN-1:0]   pattern_q, pattern_d;
    logic [c_idx_w-1:0]       index_q,   index_d;
    logic [c_cnt_w-1:0]       period_q,  period_d;
    logic                     seq_q,     seq_d;
    logic                     busy_q,    busy_d;
    logic                     done_q,    done_d;
    logic [6:0]               led_q,     led_d;

    logic [c_idx_w-1:0]       w_index_inc;
    logic [c_idx_w-1:0]       w_bit_sel;
    logic                     w_bit_last;
    logic [3:0]               w_digit;

    assign w_index_inc = index_q + c_idx_w'(1);
    assign w_bit_sel   = c_last_idx - w_index_inc;
    assign w_bit_last  = (period_q == c_period_last);
    assign w_digit     = 4'(index_d);

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        index_d   = index_q;
        period_d  = period_q;
        seq_d     = seq_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                seq_d    = 1'b0;
                busy_d   = 1'b0;
                index_d  = '0;
                period_d = '0;
                if (pattern_load) begin
                    pattern_d = pattern_in;
                end
                // A load in the same cycle as start must already feed the first bit.
                if (start) begin
                    state_d = ST_SEND;
                    busy_d  = 1'b1;
                    seq_d   = pattern_load ? pattern_in[PATTERN_LEN-1]
                                           : pattern_q[PATTERN_LEN-1];
                end
            end

            ST_SEND: begin
                if (abort) begin
                    state_d  = ST_IDLE;
                    seq_d    = 1'b0;
                    busy_d   = 1'b0;
                    index_d  = '0;
                    period_d = '0;
                end else if (w_bit_last) begin
                    period_d = '0;
                    if (index_q == c_last_idx) begin
                        if (repeat_en) begin
                            index_d = '0;
                            seq_d   = pattern_q[PATTERN_LEN-1];
                        end else begin
                            state_d = ST_DONE;
                            seq_d   = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            index_d = '0;
                        end
                    end else begin
                        index_d = w_index_inc;
                        seq_d   = pattern_q[w_bit_sel];
                    end
                end else begin
                    period_d = period_q + c_cnt_w'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                seq_d   = 1'b0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                seq_d   = 1'b0;
                busy_d  = 1'b0;
                index_d = '0;
            end
        endcase
    end

    seg7_digit u_seg7_digit (
        .digit_i (w_digit),
        .seg_o   (led_d)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pattern_q <= PATTERN;
            index_q   <= '0;
            period_q  <= '0;
            seq_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            led_q     <= c_seg_digits[0];
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            index_q   <= index_d;
            period_q  <= period_d;
            seq_q     <= seq_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            led_q     <= led_d;
        end
    end

    assign sequence_out = seq_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign LED_out      = led_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// tb_seq_pattern_tx : scoreboard bench for seq_pattern_tx (BIT_PERIOD 1 and 3)
// Revision: 1.0
// ============================================================================
module tb_seq_pattern_tx;

    typedef struct packed {
        logic       seq;
        logic       busy;
        logic       done;
        logic [6:0] led;
    } rec_t;

    localparam logic [9:0] c_default = 10'b1011001010;
    localparam logic [9:0] c_alt     = 10'b1111000011;

    logic       clock = 1'b0;
    logic       reset;
    logic       start, abort, repeat_en, pattern_load;
    logic [9:0] pattern_in;
    logic       start3;

    logic       seq1, busy1, done1;
    logic [6:0] led1;
    logic       seq3, busy3, done3;
    logic [6:0] led3;

    rec_t q1[$];
    rec_t q2[$];
    rec_t e1, e2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] seg_tab [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                  7'b0000000, 7'b0000100};

    always #5 clock = ~clock;

    seq_pattern_tx u_dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .repeat_en    (repeat_en),
        .pattern_load (pattern_load),
        .pattern_in   (pattern_in),
        .sequence_out (seq1),
        .busy         (busy1),
        .done         (done1),
        .LED_out      (led1)
    );

    seq_pattern_tx #(.BIT_PERIOD(3)) u_dut3 (
        .clock        (clock),
        .reset        (reset),
        .start        (start3),
        .abort        (1'b0),
        .repeat_en    (1'b0),
        .pattern_load (1'b0),
        .pattern_in   (10'b0),
        .sequence_out (seq3),
        .busy         (busy3),
        .done         (done3),
        .LED_out      (led3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: pop one expected record whenever a DUT presents output.
    always @(negedge clock) begin
        if (!reset && (busy1 || done1)) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut1_unexpected: got seq=%0b busy=%0b done=%0b with empty queue at %0t",
                         seq1, busy1, done1, $time);
            end else begin
                e1 = q1.pop_front();
                check("dut1_out", {22'b0, seq1, busy1, done1, led1}, {22'b0, e1});
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && (busy3 || done3)) begin
            if (q2.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut3_unexpected: got seq=%0b busy=%0b done=%0b with empty queue at %0t",
                         seq3, busy3, done3, $time);
            end else begin
                e2 = q2.pop_front();
                check("dut3_out", {22'b0, seq3, busy3, done3, led3}, {22'b0, e2});
            end
        end
    end

    task automatic push_frame(input int which, input logic [9:0] p, input int bp,
                              input int nbits, input bit with_done);
        rec_t r;
        for (int i = 0; i < nbits; i++) begin
            for (int k = 0; k < bp; k++) begin
                r = '{seq: p[9-i], busy: 1'b1, done: 1'b0, led: seg_tab[i]};
                if (which == 1) q1.push_back(r); else q2.push_back(r);
            end
        end
        if (with_done) begin
            r = '{seq: 1'b0, busy: 1'b0, done: 1'b1, led: seg_tab[0]};
            if (which == 1) q1.push_back(r); else q2.push_back(r);
        end
    endtask

    task automatic pulse_start(input bit load, input logic [9:0] pin);
        @(posedge clock); #1;
        start        = 1'b1;
        pattern_load = load;
        pattern_in   = pin;
        @(posedge clock); #1;
        start        = 1'b0;
        pattern_load = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 300; k++) begin
            if (q1.size() == 0 && q2.size() == 0 && !busy1 && !busy3 && !done1 && !done3) break;
            @(posedge clock); #1;
        end
        check("drain_remaining", q1.size() + q2.size(), 0);
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        int cnt;
        reset = 1'b1; start = 1'b0; abort = 1'b0; repeat_en = 1'b0;
        pattern_load = 1'b0; pattern_in = 10'b0; start3 = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", {seq1, busy1, done1, led1}, {3'b000, 7'b0000001});
        check("reset_outputs3", {seq3, busy3, done3, led3}, {3'b000, 7'b0000001});
        reset = 1'b0;

        // One-shot default frame
        push_frame(1, c_default, 1, 10, 1'b1);
        pulse_start(1'b0, 10'b0);
        check("first_bit_latency", {seq1, busy1, led1}, {2'b11, 7'b0000001});
        repeat (10) @(posedge clock);
        #1;
        check("done_cycle11", {done1, busy1}, 2'b10);
        wait_drain();

        // Three back-to-back frames via repeat_en
        repeat_en = 1'b1;
        push_frame(1, c_default, 1, 10, 1'b0);
        push_frame(1, c_default, 1, 10, 1'b0);
        push_frame(1, c_default, 1, 10, 1'b1);
        pulse_start(1'b0, 10'b0);
        cnt = 0;
        while (busy1 && cnt < 40) begin
            cnt++;
            if (cnt == 25) repeat_en = 1'b0;
            @(posedge clock); #1;
        end
        check("repeat_busy_run", cnt, 30);
        check("repeat_done", done1, 1'b1);
        wait_drain();

        // Abort at index 4; start and zero-load during frame are ignored
        push_frame(1, c_default, 1, 5, 1'b0);
        pulse_start(1'b0, 10'b0);
        @(posedge clock); #1;
        start = 1'b1; pattern_load = 1'b1; pattern_in = 10'b0;
        repeat (2) @(posedge clock);
        #1;
        start = 1'b0; pattern_load = 1'b0;
        @(posedge clock); #1;
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        check("abort_outputs", {seq1, busy1, done1, led1}, {3'b000, 7'b0000001});
        @(posedge clock); #1;
        check("abort_no_done", done1, 1'b0);
        wait_drain();
        push_frame(1, c_default, 1, 10, 1'b1);
        pulse_start(1'b0, 10'b0);
        wait_drain();

        // Load together with start, then resend without load
        push_frame(1, c_alt, 1, 10, 1'b1);
        pulse_start(1'b1, c_alt);
        wait_drain();
        push_frame(1, c_alt, 1, 10, 1'b1);
        pulse_start(1'b0, 10'b0);
        wait_drain();

        // Asynchronous reset mid-frame restores outputs and default pattern
        push_frame(1, c_alt, 1, 10, 1'b1);
        pulse_start(1'b0, 10'b0);
        repeat (3) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", {seq1, busy1, done1, led1}, {3'b000, 7'b0000001});
        q1.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        push_frame(1, c_default, 1, 10, 1'b1);
        pulse_start(1'b0, 10'b0);
        wait_drain();

        // BIT_PERIOD = 3 instance
        push_frame(2, c_default, 3, 10, 1'b1);
        @(posedge clock); #1;
        start3 = 1'b1;
        @(posedge clock); #1;
        start3 = 1'b0;
        check("bp3_first_bit", {seq3, busy3}, 2'b11);
        repeat (30) @(posedge clock);
        #1;
        check("bp3_done_cycle31", {done3, busy3}, 2'b10);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
